layer4_weight_sched: RTL
========================

// Module: layer4_weight_sched
// PURPOSE
//  Scheduler that shares one incoming weight stream between the two convolutions of a layer-4 basic block.
//  On start, routes exactly W1_COUNT words to the conv1 weight port (1x1, 512->512), then W2_COUNT words to conv2 (3x3, 512->512).
//  Pulses done when both loads are complete. Sits between the weight source (memory/DMA) and valid_weight_in1/2 of the basic block.
// PARAMETERS
//  DATA_WIDTH  32         weight word width
//  W1_COUNT    262144     words for conv1 (512*512*1)
//  W2_COUNT    2359296    words for conv2 (512*512*9)
//  CNT_WIDTH   32         transfer counter width; must hold max(W1_COUNT,W2_COUNT)
// PORTS
//  clk                input   1           clock, all logic on rising edge
//  reset              input   1           synchronous, active-high
//  start              input   1           one-cycle request to begin a load sequence
//  src_valid          input   1           source word valid
//  src_data           input   DATA_WIDTH  source weight word
//  src_ready          output  1           scheduler accepts src_data this cycle
//  valid_weight_out1  output  1           weight valid to conv1
//  weight_out1        output  DATA_WIDTH  weight word to conv1
//  valid_weight_out2  output  1           weight valid to conv2
//  weight_out2        output  DATA_WIDTH  weight word to conv2
//  busy               output  1           high in LOAD1/LOAD2
//  done               output  1           one-cycle pulse after the last conv2 word
// BEHAVIOUR
//  - Reset (synchronous, active-high): state=IDLE, counter=0; src_ready, valid_weight_out1/2, busy, done = 0; weight_out1/2 = 0.
//  - FSM states: IDLE, LOAD1, LOAD2, DONE.
//    IDLE : start=1 -> LOAD1 (counter=0); else stay.
//    LOAD1: each accepted word increments counter; the word accepted with counter==W1_COUNT-1 -> LOAD2, counter=0.
//    LOAD2: same with W2_COUNT; the last word -> DONE.
//    DONE : done=1 for exactly this one cycle -> IDLE unconditionally.
//  - src_ready = (state==LOAD1 || state==LOAD2), decoded from the registered state; no combinational path from src_valid.
//  - Transfer = src_valid && src_ready. Words with src_valid=1 while src_ready=0 are not consumed (source holds them).
//  - Outputs are registered, 1-cycle latency: a transfer in cycle N gives valid_weight_outX=1 and weight_outX=src_data in cycle N+1.
//    X=1 if the transfer happened in LOAD1, X=2 if in LOAD2; never both in the same cycle.
//  - With no transfer in cycle N, valid_weight_out1/2=0 in N+1. weight_out1/2 hold their last value.
//  - The LOAD1->LOAD2 switch costs no bubble: the first conv2 word can be accepted in the cycle after the last conv1 word.
//  - done asserts in the cycle after the last conv2 word is accepted, the same cycle as that word's valid_weight_out2.
//  - busy = (state==LOAD1 || state==LOAD2).
//  - start while busy or in DONE: ignored; no restart, no queueing.
//  - start and reset in the same cycle: reset wins.
//  - Reset mid-load: sequence aborted, counter cleared, any pending output valid dropped, no done pulse. A later start restarts from conv1 word 0.
//  - Counter compares against COUNT-1 at CNT_WIDTH bits; W1_COUNT and W2_COUNT must be >= 1. No wrap-around occurs within a state.
// TESTING (bench uses W1_COUNT=4, W2_COUNT=9)
//  1. reset, then src_valid=1 held with no start -> src_ready=0, no valid_weight_out*, busy=0 for 20 cycles.
//  2. start + continuous src_valid, data 0..12 -> weight_out1 = 0,1,2,3 on 4 consecutive cycles;
//     weight_out2 = 4..12 on the following 9 consecutive cycles; done=1 once, together with the 12; then idle.
//  3. same as 2 with src_valid toggling 1,0,1,0 -> same words in the same order, gaps on valid_weight_out*; done only after the 13th transfer.
//  4. start pulsed again during LOAD2 and during DONE -> no effect on counts; exactly one done; next start begins at conv1 again.
//  5. reset asserted after 6 transfers -> all outputs 0 the next cycle, no done;
//     a new start plus 13 words -> full 4+9 sequence from word 0.
//  6. back-to-back: start in the cycle after done -> second sequence identical to scenario 2; 13 transfers and one done each.

Source files
------------

// File: rtl/layer4_weight_sched.sv
// layer4_weight_sched: splits one weight stream into the conv1 and conv2
// weight ports of a layer-4 basic block, then pulses done.
module layer4_weight_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int W1_COUNT   = 262144,
  parameter int W2_COUNT   = 2359296,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  valid_weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic                  valid_weight_out2,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] W1_LAST =
    CNT_WIDTH'(W1_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] W2_LAST =
    CNT_WIDTH'(W2_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD1,
    LOAD2,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_in_load;
  logic                  w_xfer;
  logic                  w_xfer1;
  logic                  w_xfer2;
  logic                  r_vld1;
  logic                  r_vld2;
  logic [DATA_WIDTH-1:0] r_wgt1;
  logic [DATA_WIDTH-1:0] r_wgt2;

  // State register and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter update and load-phase decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_in_load   = 1'b0;
    w_xfer1     = 1'b0;
    w_xfer2     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LOAD1;
          w_cnt_nxt   = '0;
        end
      end
      LOAD1: begin
        w_in_load = 1'b1;
        w_xfer1   = src_valid;
        if (src_valid) begin
          if (r_cnt == W1_LAST) begin
            w_state_nxt = LOAD2;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      LOAD2: begin
        w_in_load = 1'b1;
        w_xfer2   = src_valid;
        if (src_valid) begin
          if (r_cnt == W2_LAST) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_xfer = w_xfer1 | w_xfer2;

  // Registered weight outputs; data holds between transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
      r_wgt1 <= '0;
      r_wgt2 <= '0;
    end else begin
      r_vld1 <= w_xfer1;
      r_vld2 <= w_xfer2;
      if (w_xfer1) begin
        r_wgt1 <= src_data;
      end
      if (w_xfer2) begin
        r_wgt2 <= src_data;
      end
    end
  end

  assign src_ready         = w_in_load;
  assign busy              = w_in_load;
  assign done              = (r_state == DONE);
  assign valid_weight_out1 = r_vld1;
  assign valid_weight_out2 = r_vld2;
  assign weight_out1       = r_wgt1;
  assign weight_out2       = r_wgt2;

  logic w_unused;
  assign w_unused = w_xfer;

endmodule
